// File: rtl/mul_div_pkg.sv
// Shared types and constants for the multiply/divide block family.
package mul_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned DEF_W = 4;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift {rem,quot} left, subtract divisor if it fits.
module div_step #(
    parameter int unsigned W = 4
) (
    input  logic [W:0]   rem,
    input  logic [W-1:0] quot,
    input  logic [W-1:0] divisor,
    output logic [W:0]   rem_next,
    output logic [W-1:0] quot_next
);

    logic [W:0]   rem_sh;
    logic [W-1:0] quot_sh;

    // rem is always < divisor on entry, so its MSB is zero and the shift cannot lose data
    assign rem_sh  = {rem[W-1:0], quot[W-1]};
    assign quot_sh = {quot[W-2:0], 1'b0};

    always_comb begin
        rem_next  = rem_sh;
        quot_next = quot_sh;
        if (rem_sh >= {1'b0, divisor}) begin
            rem_next  = rem_sh - {1'b0, divisor};
            quot_next = quot_sh | W'(1);
        end
    end

endmodule

// File: rtl/seq_div.sv
// Sequential unsigned restoring divider, one quotient bit per cycle.
// Optional DIV_BY_ZERO_EN: short-circuits b==0 straight to DONE with err=1.
module seq_div
    import mul_div_pkg::*;
#(
    parameter int unsigned W = DEF_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] q,
    output logic [W-1:0] r,
    output logic         err
);

    localparam int unsigned CW = $clog2(W + 1);

    state_e        state_q, state_d;
    logic [W:0]    rem_q, rem_d;
    logic [W-1:0]  quot_q, quot_d;
    logic [W-1:0]  div_q, div_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  q_q, q_d;
    logic [W-1:0]  r_q, r_d;
    logic [W:0]    step_rem;
    logic [W-1:0]  step_quot;
`ifdef DIV_BY_ZERO_EN
    logic          err_q, err_d;
`endif

    div_step #(.W(W)) u_step (
        .rem       (rem_q),
        .quot      (quot_q),
        .divisor   (div_q),
        .rem_next  (step_rem),
        .quot_next (step_quot)
    );

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        quot_d  = quot_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
`ifdef DIV_BY_ZERO_EN
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    // dividend is loaded into the quotient register and shifted out as quotient bits shift in
                    div_d   = b;
                    quot_d  = a;
                    rem_d   = '0;
                    cnt_d   = CW'(W);
                    state_d = RUN;
`ifdef DIV_BY_ZERO_EN
                    if (b == '0) begin
                        state_d = DONE;
                        cnt_d   = '0;
                        q_d     = '1;
                        r_d     = a;
                        err_d   = 1'b1;
                    end
`endif
                end
            end
            RUN: begin
                rem_d  = step_rem;
                quot_d = step_quot;
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                    q_d     = step_quot;
                    r_d     = step_rem[W-1:0];
`ifdef DIV_BY_ZERO_EN
                    err_d   = 1'b0;
`endif
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            quot_q  <= '0;
            div_q   <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
`ifdef DIV_BY_ZERO_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            quot_q  <= quot_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
`ifdef DIV_BY_ZERO_EN
            err_q   <= err_d;
`endif
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign q    = q_q;
    assign r    = r_q;
`ifdef DIV_BY_ZERO_EN
    assign err  = err_q;
`else
    assign err  = 1'b0;
`endif

endmodule
